// File: rtl/pcm_pwm_player_pkg.sv
// Shared audio definitions: fetch FSM encoding, default sample width and the
// FIFO read latency that every FIFO reader in the audio path assumes.
package pcm_pwm_player_pkg;

  localparam int unsigned AUDIO_DBITS = 8;
  localparam int unsigned FIFO_RD_LAT = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_HI = 3'd1,
    RD_LO = 3'd2,
    WAIT  = 3'd3,
    LOAD  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/pcm_pwm_player_pwm_gen.sv
// Free-running PWM generator: counter, wrap flag for period-aligned sample
// updates, and a registered comparator output gated by enable.
module pwm_gen
  import pcm_pwm_player_pkg::*;
#(
  parameter int unsigned DBITS = AUDIO_DBITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [DBITS-1:0] sample,
  output logic             wrap,
  output logic             pwm_out
);

  logic [DBITS-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt     <= cnt + 1'b1;
      pwm_out <= (cnt < sample) & enable;
    end
  end

  // High on the last count; the next edge takes the counter back to 0.
  assign wrap = (cnt == '1);

endmodule

// File: rtl/pcm_pwm_player.sv
// PCM player: reads one sample per tick from the audio FIFO with a strobe
// handshake and plays it through pwm_gen, switching samples only at PWM wraps.
module pcm_pwm_player
  import pcm_pwm_player_pkg::*;
#(
  parameter int unsigned DBITS      = AUDIO_DBITS,
  parameter int unsigned SAMPLE_DIV = 1024,
  parameter int unsigned RD_LAT     = FIFO_RD_LAT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [DBITS-1:0] fifo_dout,
  output logic             fifo_rd,
  output logic             pwm_out,
  output logic [DBITS-1:0] sample_out,
  output logic             underrun,
  output logic [15:0]      underrun_cnt,
  output logic             busy
);

  localparam int unsigned TW = $clog2(SAMPLE_DIV);
  localparam int unsigned WW = $clog2(RD_LAT);

  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [WW-1:0]    wait_cnt;
  fetch_state_t     state, state_next;
  logic             miss;
  logic [DBITS-1:0] pending_reg;
  logic             pending_valid;
  logic             wrap;

  assign tick = enable && (tick_cnt == TW'(SAMPLE_DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                tick_cnt <= '0;
    else if (!enable || tick) tick_cnt <= '0;
    else                      tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_next = state;
    miss       = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          if (!fifo_empty) state_next = RD_HI;
          else             miss       = 1'b1;
        end
      end
      RD_HI:   state_next = RD_LO;
      RD_LO:   state_next = WAIT;
      WAIT:    if (wait_cnt == WW'(RD_LAT - 2)) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign fifo_rd = (state == RD_HI);
  assign busy    = (state != IDLE);

  // A fetched word waits in pending_reg until the next PWM wrap so the
  // duty cycle never changes mid-period.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      underrun      <= 1'b0;
      underrun_cnt  <= '0;
      pending_reg   <= '0;
      pending_valid <= 1'b0;
      sample_out    <= '0;
    end else begin
      underrun <= miss;
      if (miss && (underrun_cnt != '1)) underrun_cnt <= underrun_cnt + 16'd1;
      if (state == LOAD) begin
        pending_reg   <= fifo_dout;
        pending_valid <= 1'b1;
      end else if (wrap && pending_valid) begin
        pending_valid <= 1'b0;
      end
      if (wrap && pending_valid) sample_out <= pending_reg;
    end
  end

  pwm_gen #(.DBITS(DBITS)) u_pwm (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .sample  (sample_out),
    .wrap    (wrap),
    .pwm_out (pwm_out)
  );

endmodule

// File: tb/tb_pcm_pwm_player.sv
// Directed bench for pcm_pwm_player with SAMPLE_DIV equal to the PWM period,
// so sample ticks and PWM wraps share the same edge grid.
module tb_pcm_pwm_player;

  localparam int unsigned SD = 256;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        fifo_rd;
  logic        pwm_out;
  logic [7:0]  sample_out;
  logic        underrun;
  logic [15:0] underrun_cnt;
  logic        busy;

  int unsigned errors = 0;
  int unsigned checks = 0;

  pcm_pwm_player #(.DBITS(8), .SAMPLE_DIV(SD), .RD_LAT(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_dout    (fifo_dout),
    .fifo_rd      (fifo_rd),
    .pwm_out      (pwm_out),
    .sample_out   (sample_out),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  // Edge-indexed monitor, sampled 2 time units after each rising edge.
  int unsigned edges = 0;
  int unsigned rd_high = 0, rd_pulses = 0, rd_start = 0;
  int unsigned ur_high = 0, ur_pulses = 0;
  int unsigned pwm_high = 0;
  int unsigned sample_changes = 0, bad_changes = 0;
  logic        prev_rd = 1'b0, prev_ur = 1'b0;
  logic [7:0]  prev_sample = '0;

  always @(posedge clock) begin
    #2;
    if (reset) begin
      edges = 0;
    end else begin
      edges++;
      if (fifo_rd) begin
        rd_high++;
        if (!prev_rd) begin
          rd_pulses++;
          rd_start = edges;
        end
      end
      if (underrun) begin
        ur_high++;
        if (!prev_ur) ur_pulses++;
      end
      if (pwm_out) pwm_high++;
      if (sample_out !== prev_sample) begin
        sample_changes++;
        if ((edges % SD) != 0) bad_changes++;
      end
    end
    prev_rd     = fifo_rd;
    prev_ur     = underrun;
    prev_sample = sample_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_edge(input int unsigned n);
    while (edges < n) @(negedge clock);
  endtask

  int unsigned ph, r0, r1, u0, uh0;

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    fifo_empty = 1'b0;
    fifo_dout  = 8'h40;
    repeat (3) @(negedge clock);
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_pwm_out", pwm_out, 0);
    check("rst_sample", sample_out, 0);
    check("rst_underrun", underrun, 0);
    check("rst_ur_cnt", underrun_cnt, 0);
    check("rst_busy", busy, 0);
    reset  = 1'b0;
    enable = 1'b1;

    // First fetch: strobe after SAMPLE_DIV edges, applied at the following wrap
    wait_edge(300);
    check("first_rd_pulses", rd_pulses, 1);
    check("first_rd_edge", rd_start, SD);
    check("first_rd_width", rd_high, 1);
    check("first_busy_idle", busy, 0);
    fifo_dout = 8'h00;
    wait_edge(511);
    check("sample_before_wrap", sample_out, 8'h00);
    wait_edge(512);
    check("sample_40", sample_out, 8'h40);
    ph = pwm_high;
    wait_edge(600);
    fifo_dout = 8'hFF;
    wait_edge(768);
    check("duty_40", pwm_high - ph, 64);
    check("sample_00", sample_out, 8'h00);
    ph = pwm_high;
    wait_edge(856);
    fifo_dout = 8'h80;
    wait_edge(1024);
    check("duty_00", pwm_high - ph, 0);
    check("sample_ff", sample_out, 8'hFF);
    ph = pwm_high;
    wait_edge(1100);
    fifo_empty = 1'b1;
    wait_edge(1280);
    check("duty_ff", pwm_high - ph, 255);
    check("sample_80", sample_out, 8'h80);
    ph = pwm_high;
    wait_edge(1536);
    check("duty_80", pwm_high - ph, 128);
    check("changes_count", sample_changes, 4);
    check("changes_aligned", bad_changes, 0);

    // Three empty ticks at 1280/1536/1792
    wait_edge(1800);
    check("ur_pulses", ur_pulses, 3);
    check("ur_width", ur_high, 3);
    check("ur_cnt_3", underrun_cnt, 3);
    check("ur_no_read", rd_pulses, 4);
    check("ur_sample_hold", sample_out, 8'h80);

    // Preload the counter just below saturation, then two more empty ticks
    wait_edge(1900);
    force dut.underrun_cnt = 16'hFFFE;
    #1;
    release dut.underrun_cnt;
    wait_edge(2100);
    check("ur_cnt_ffff", underrun_cnt, 16'hFFFF);
    wait_edge(2310);
    check("ur_cnt_sat", underrun_cnt, 16'hFFFF);
    check("ur_pulses_5", ur_pulses, 5);

    // Reset two clocks after the strobe falls (fetch strobe at 2560)
    wait_edge(2350);
    fifo_empty = 1'b0;
    fifo_dout  = 8'h11;
    wait_edge(2563);
    check("wait_busy", busy, 1);
    check("wait_rd_low", fifo_rd, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_fifo_rd", fifo_rd, 0);
    check("mid_rst_pwm", pwm_out, 0);
    check("mid_rst_sample", sample_out, 0);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_ur_cnt", underrun_cnt, 0);
    check("mid_rst_busy", busy, 0);
    fifo_dout = 8'h22;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    r0 = rd_pulses;
    wait_edge(255);
    check("post_rst_no_rd", rd_pulses - r0, 0);
    wait_edge(300);
    check("post_rst_no_load", sample_out, 8'h00);
    check("post_rst_rd", rd_pulses - r0, 1);
    check("post_rst_rd_edge", rd_start, SD);
    fifo_dout = 8'h33;
    wait_edge(512);
    check("post_rst_sample", sample_out, 8'h22);

    // Drop enable while the strobe is low (RD_LO)
    wait_edge(513);
    check("rdlo_busy", busy, 1);
    check("rdlo_rd_low", fifo_rd, 0);
    check("rdlo_pwm_high", pwm_out, 1);
    enable = 1'b0;
    r1 = rd_pulses;
    u0 = underrun_cnt;
    uh0 = ur_pulses;
    wait_edge(514);
    check("dis_pwm_low", pwm_out, 0);
    ph = pwm_high;
    wait_edge(767);
    check("dis_sample_hold", sample_out, 8'h22);
    wait_edge(768);
    check("dis_sample_applied", sample_out, 8'h33);
    wait_edge(1100);
    check("dis_no_rd", rd_pulses - r1, 0);
    check("dis_pwm_quiet", pwm_high - ph, 0);
    check("dis_busy", busy, 0);
    check("dis_no_ur", ur_pulses - uh0, 0);
    check("dis_ur_cnt", underrun_cnt, u0);
    check("changes_aligned_end", bad_changes, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
